// File: rtl/spi_multi_therm_model.sv
// Multi-channel thermometer model with an SPI-slave read port.
// The SPI pins are sampled into the i_clk domain, and each channel's temperature drifts on a tick.
module spi_multi_therm_model #(
  parameter int unsigned g_num_ch         = 4,
  parameter int unsigned g_temp_width     = 16,
  parameter int unsigned g_temp_init      = 700,
  parameter int unsigned g_temp_min       = 0,
  parameter int unsigned g_temp_max       = 1200,
  parameter int unsigned g_temp_chg_ticks = 6000,
  parameter int unsigned g_amb_div        = 4
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_spi_clk,
  input  logic                               i_spi_cs_n,
  input  logic                               i_spi_si,
  output logic                               o_spi_so,
  output logic                               o_spi_so_en,
  input  logic [g_num_ch-1:0]                i_heat,
  input  logic [g_num_ch-1:0]                i_cool,
  input  logic [g_num_ch-1:0]                i_amb_hc,
  output logic [g_num_ch*g_temp_width-1:0]   o_temp,
  output logic                               o_busy
);

  localparam int unsigned W     = g_temp_width;
  localparam int unsigned TickW = (g_temp_chg_ticks > 1) ? $clog2(g_temp_chg_ticks) : 1;
  localparam int unsigned AmbW  = (g_amb_div > 1) ? $clog2(g_amb_div) : 1;
  localparam int unsigned CntW  = $clog2(W + 9);

  localparam logic [W-1:0] TempInit = W'(g_temp_init);
  localparam logic [W-1:0] TempMin  = W'(g_temp_min);
  localparam logic [W-1:0] TempMax  = W'(g_temp_max);

  typedef enum logic [1:0] {StIdle, StCmd, StData, StTail} state_e;

  state_e            state_q;
  logic              sck_meta, sck_sync, sck_prev;
  logic              cs_meta, cs_sync, cs_prev;
  logic              si_meta, si_sync;
  logic [CntW-1:0]   bit_cnt;
  logic [6:0]        cmd_sr;
  logic [W-1:0]      shift_sr;
  logic [TickW-1:0]  tick_cnt;
  logic [AmbW-1:0]   amb_cnt;
  logic [W-1:0]      temp_q [g_num_ch];
  logic [W-1:0]      temp_d [g_num_ch];

  logic         sck_rise, sck_fall, cs_rise, cs_fall;
  logic         tick, amb_tick;
  logic [7:0]   cmd_byte;
  logic [W-1:0] snap;

  assign sck_rise = sck_sync & ~sck_prev;
  assign sck_fall = ~sck_sync & sck_prev;
  assign cs_rise  = cs_sync & ~cs_prev;
  assign cs_fall  = ~cs_sync & cs_prev;
  assign tick     = (tick_cnt == TickW'(g_temp_chg_ticks - 1));
  assign amb_tick = tick && (amb_cnt == AmbW'(g_amb_div - 1));
  assign cmd_byte = {cmd_sr, si_sync};

  // Unknown opcodes and out-of-range channels read back as all ones.
  always_comb begin
    snap = '1;
    for (int k = 0; k < int'(g_num_ch); k++) begin
      if (cmd_byte[7:6] == 2'b01 && cmd_byte[5:0] == 6'(k)) snap = temp_q[k];
    end
  end

  always_comb begin
    for (int k = 0; k < int'(g_num_ch); k++) begin
      temp_d[k] = temp_q[k];
      if (tick) begin
        if (i_heat[k] && !i_cool[k]) begin
          temp_d[k] = (temp_q[k] >= TempMax) ? TempMax : temp_q[k] + 1'b1;
        end else if (i_cool[k] && !i_heat[k]) begin
          temp_d[k] = (temp_q[k] <= TempMin) ? TempMin : temp_q[k] - 1'b1;
        end else if (amb_tick) begin
          if (i_amb_hc[k]) temp_d[k] = (temp_q[k] >= TempMax) ? TempMax : temp_q[k] + 1'b1;
          else             temp_d[k] = (temp_q[k] <= TempMin) ? TempMin : temp_q[k] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tick_cnt <= '0;
      amb_cnt  <= '0;
      for (int k = 0; k < int'(g_num_ch); k++) temp_q[k] <= TempInit;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) amb_cnt <= (amb_cnt == AmbW'(g_amb_div - 1)) ? '0 : amb_cnt + 1'b1;
      for (int k = 0; k < int'(g_num_ch); k++) temp_q[k] <= temp_d[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      sck_meta <= 1'b0;
      sck_sync <= 1'b0;
      sck_prev <= 1'b0;
      cs_meta  <= 1'b1;
      cs_sync  <= 1'b1;
      cs_prev  <= 1'b1;
      si_meta  <= 1'b0;
      si_sync  <= 1'b0;
      bit_cnt  <= '0;
      cmd_sr   <= '0;
      shift_sr <= '0;
    end else begin
      sck_meta <= i_spi_clk;
      sck_sync <= sck_meta;
      sck_prev <= sck_sync;
      cs_meta  <= i_spi_cs_n;
      cs_sync  <= cs_meta;
      cs_prev  <= cs_sync;
      si_meta  <= i_spi_si;
      si_sync  <= si_meta;
      if (cs_rise) begin
        state_q <= StIdle;
        bit_cnt <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cs_fall) begin
              state_q <= StCmd;
              bit_cnt <= '0;
              cmd_sr  <= '0;
            end
          end
          StCmd: begin
            if (sck_rise) begin
              cmd_sr <= cmd_byte[6:0];
              if (bit_cnt == CntW'(7)) begin
                state_q  <= StData;
                shift_sr <= snap;
                bit_cnt  <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          StData: begin
            // bit_cnt counts bits the master has sampled; the fall right after the
            // last command bit must not shift, since the MSB is not yet sampled.
            if (sck_rise) begin
              if (bit_cnt != CntW'(W)) bit_cnt <= bit_cnt + 1'b1;
            end else if (sck_fall && bit_cnt != '0) begin
              if (bit_cnt == CntW'(W)) state_q <= StTail;
              else                     shift_sr <= {shift_sr[W-2:0], 1'b0};
            end
          end
          StTail: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign o_spi_so    = (state_q == StData) & shift_sr[W-1];
  assign o_spi_so_en = (state_q == StData) | (state_q == StTail);
  assign o_busy      = (state_q != StIdle);

  for (genvar k = 0; k < int'(g_num_ch); k++) begin : g_temp_out
    assign o_temp[k*W +: W] = temp_q[k];
  end

endmodule

// File: tb/tb_spi_multi_therm_model.sv
// Directed bench: SPI reads scored against a behavioural temperature model via an expected-word queue.
module tb_spi_multi_therm_model;

  localparam int T    = 1000;
  localparam int AMB  = 4;
  localparam int TMIN = 696;
  localparam int TMAX = 704;
  localparam int INIT = 700;

  logic        clk, rst, sck, cs_n, si, so, so_en, busy;
  logic [3:0]  heat, cool, amb;
  logic [63:0] temp;

  int checks = 0;
  int failures = 0;
  logic [15:0] sb[$];

  int          m_cyc;
  int          m_ticks;
  logic [15:0] m_temp [4];

  spi_multi_therm_model #(
    .g_num_ch(4), .g_temp_width(16), .g_temp_init(INIT), .g_temp_min(TMIN),
    .g_temp_max(TMAX), .g_temp_chg_ticks(T), .g_amb_div(AMB)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_spi_clk(sck), .i_spi_cs_n(cs_n), .i_spi_si(si),
    .o_spi_so(so), .o_spi_so_en(so_en), .i_heat(heat), .i_cool(cool), .i_amb_hc(amb),
    .o_temp(temp), .o_busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] up(input logic [15:0] x);
    return (x >= 16'(TMAX)) ? 16'(TMAX) : x + 16'd1;
  endfunction

  function automatic logic [15:0] dn(input logic [15:0] x);
    return (x <= 16'(TMIN)) ? 16'(TMIN) : x - 16'd1;
  endfunction

  // Reference model: tick every T cycles after reset, ambient every AMB-th tick.
  always @(posedge clk) begin
    if (rst) begin
      m_cyc   <= 0;
      m_ticks <= 0;
      for (int k = 0; k < 4; k++) m_temp[k] <= 16'(INIT);
    end else begin
      m_cyc <= m_cyc + 1;
      if ((m_cyc + 1) % T == 0) begin
        m_ticks <= m_ticks + 1;
        for (int k = 0; k < 4; k++) begin
          if (heat[k] && !cool[k])      m_temp[k] <= up(m_temp[k]);
          else if (cool[k] && !heat[k]) m_temp[k] <= dn(m_temp[k]);
          else if ((m_ticks + 1) % AMB == 0) m_temp[k] <= amb[k] ? up(m_temp[k]) : dn(m_temp[k]);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] temp_of(input int k);
    return temp[k*16 +: 16];
  endfunction

  task automatic check_model(input string tag);
    for (int k = 0; k < 4; k++) check($sformatf("%s_ch%0d", tag, k), 32'(temp_of(k)), 32'(m_temp[k]));
  endtask

  // Park the bench early in a tick period so a whole read sees no tick.
  task automatic wait_window(input int hi);
    while ((m_cyc % T) < 2 || (m_cyc % T) > hi) clk_n(1);
  endtask

  task automatic spi_read(input logic [7:0] cmd, input bit align, input string tag,
                          output logic [15:0] snap_exp);
    logic [15:0] got;
    logic [15:0] exp;
    cs_n = 1'b0;
    clk_n(4);
    for (int i = 7; i >= 0; i--) begin
      si = cmd[i];
      clk_n(4);
      if (i == 0) begin
        // Snapshot lands on the third rising edge after this SCK rise.
        if (align) while ((m_cyc % T) != T - 3) clk_n(1);
        if (cmd[7:6] == 2'b01 && cmd[5:0] < 6'd4) exp = m_temp[cmd[1:0]];
        else                                       exp = 16'hFFFF;
        sb.push_back(exp);
        snap_exp = exp;
        check({tag, "_so_en_cmd"}, 32'(so_en), 32'd0);
      end
      sck = 1'b1;
      clk_n(4);
      sck = 1'b0;
    end
    for (int i = 15; i >= 0; i--) begin
      clk_n(4);
      got[i] = so;
      if (i == 15 || i == 0) check({tag, "_so_en_data"}, 32'(so_en), 32'd1);
      sck = 1'b1;
      clk_n(4);
      sck = 1'b0;
    end
    clk_n(4);
    check({tag, "_so_en_tail"}, 32'(so_en), 32'd1);
    check({tag, "_so_tail"}, 32'(so), 32'd0);
    cs_n = 1'b1;
    clk_n(4);
    check({tag, "_so_en_idle"}, 32'(so_en), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      exp = sb.pop_front();
      check({tag, "_data"}, 32'(got), 32'(exp));
    end
  endtask

  initial begin
    logic [15:0] snap;
    logic [15:0] pre;
    logic [15:0] held [4];
    int target;

    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; si = 1'b0;
    heat = 4'b0000; cool = 4'b0000; amb = 4'b1111;
    clk_n(3);
    check("rst_so", 32'(so), 32'd0);
    check("rst_so_en", 32'(so_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) check($sformatf("rst_temp%0d", k), 32'(temp_of(k)), INIT);
    rst = 1'b0;
    clk_n(2);

    // Read channel 2 right after reset: 0x02BC.
    spi_read(8'h42, 1'b0, "rd42", snap);
    check("rd42_value", 32'(snap), 32'h02BC);

    // Heat channel 1 for three ticks; no ambient step yet.
    heat = 4'b0010;
    while (m_cyc < 3 * T + 5) clk_n(1);
    check("heat_ch1", 32'(temp_of(1)), 32'd703);
    check("heat_ch0", 32'(temp_of(0)), INIT);
    check("heat_ch2", 32'(temp_of(2)), INIT);
    check("heat_ch3", 32'(temp_of(3)), INIT);
    heat = 4'b0000;
    wait_window(500);
    spi_read(8'h41, 1'b0, "rd41", snap);

    // Invalid channel and invalid opcode, temperatures untouched.
    wait_window(500);
    for (int k = 0; k < 4; k++) held[k] = m_temp[k];
    spi_read(8'h47, 1'b0, "rd47", snap);
    spi_read(8'h80, 1'b0, "rd80", snap);
    for (int k = 0; k < 4; k++) check($sformatf("inv_hold%0d", k), 32'(temp_of(k)), 32'(held[k]));
    check_model("after_inv");

    // Snapshot taken on the tick edge must carry the pre-tick value.
    cool = 4'b0001;
    spi_read(8'h40, 1'b1, "rd40_tick", pre);
    check("tick_decrement", 32'(temp_of(0)), 32'(pre - 16'd1));
    cool = 4'b0000;

    // Saturation at both limits.
    heat = 4'b0100; cool = 4'b1000; amb = 4'b0011;
    target = (m_cyc / T + 16) * T + 5;
    while (m_cyc < target) clk_n(1);
    check("sat_max", 32'(temp_of(2)), TMAX);
    check("sat_min", 32'(temp_of(3)), TMIN);
    check_model("after_sat");
    wait_window(500);
    spi_read(8'h42, 1'b0, "rd_max", snap);
    heat = 4'b0000; cool = 4'b0000;

    // Aborted command, then a full read of channel 3.
    wait_window(300);
    cs_n = 1'b0;
    clk_n(4);
    for (int i = 7; i >= 4; i--) begin
      si = i[0];
      clk_n(4); sck = 1'b1; clk_n(4); sck = 1'b0;
    end
    check("abort_busy_cmd", 32'(busy), 32'd1);
    cs_n = 1'b1;
    clk_n(3);
    check("abort_busy_drop", 32'(busy), 32'd0);
    clk_n(4);
    spi_read(8'h43, 1'b0, "rd43", snap);

    // Reset in the middle of a data phase.
    cs_n = 1'b0;
    clk_n(4);
    for (int i = 7; i >= 0; i--) begin
      si = (i == 6 || i == 0);
      clk_n(4); sck = 1'b1; clk_n(4); sck = 1'b0;
    end
    clk_n(4); sck = 1'b1; clk_n(4); sck = 1'b0; clk_n(4);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    clk_n(2);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_so_en", 32'(so_en), 32'd0);
    check("mid_rst_temp1", 32'(temp_of(1)), INIT);
    cs_n = 1'b1;
    clk_n(2);
    rst = 1'b0;
    clk_n(4); sck = 1'b1; clk_n(4); sck = 1'b0; clk_n(4);
    check("post_rst_idle", 32'(busy), 32'd0);
    check("post_rst_so_en", 32'(so_en), 32'd0);
    spi_read(8'h40, 1'b0, "rd_post", snap);
    check("rd_post_value", 32'(snap), INIT);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_multi_therm_model.md
SPI_MULTI_THERM_MODEL -- requirements
Module: spi_multi_therm_model

Interface
REQ-001 Parameter g_num_ch, default 4: number of independent thermometer channels, 1..64.
REQ-002 Parameter g_temp_width, default 16: temperature word width in bits, unsigned, unit 0.1 F.
REQ-003 Parameter g_temp_init, default 700: reset value of every channel's temperature.
REQ-004 Parameter g_temp_min, default 0, and g_temp_max, default 1200: saturation limits, inclusive.
REQ-005 Parameter g_temp_chg_ticks, default 6000: i_clk cycles per active heat/cool step.
REQ-006 Parameter g_amb_div, default 4: active steps per ambient drift step.
REQ-007 i_clk  in  1  system clock; all logic is single-clock, rising edge.
REQ-008 i_reset  in  1  synchronous, active-high reset.
REQ-009 i_spi_clk  in  1  SPI clock from master, mode 0, asynchronous to i_clk.
REQ-010 i_spi_cs_n  in  1  chip select, active low.
REQ-011 i_spi_si  in  1  master-out data.
REQ-012 o_spi_so  out  1  slave-out data.
REQ-013 o_spi_so_en  out  1  high while this block drives the shared SO line.
REQ-014 i_heat  in  g_num_ch  per-channel heat call, active high.
REQ-015 i_cool  in  g_num_ch  per-channel cool call, active high.
REQ-016 i_amb_hc  in  g_num_ch  per-channel ambient: 1 = warming, 0 = cooling.
REQ-017 o_temp  out  g_num_ch*g_temp_width  flat current temperatures, channel k at bits [k*W+W-1 : k*W].
REQ-018 o_busy  out  1  high in any state other than IDLE.

Function
REQ-019 i_spi_clk, i_spi_cs_n and i_spi_si each pass through a 2-flop synchroniser; edges are detected on synchronised values; i_clk is at least 4x the SPI clock.
REQ-020 States: IDLE, CMD, DATA, TAIL.
REQ-021 IDLE -> CMD on synchronised CS falling edge; bit counter cleared.
REQ-022 CMD: SI sampled on each SCK rising edge, MSB first, 8 bits; after the 8th bit -> DATA.
REQ-023 Command byte: bits[7:6] = 2'b01 is read, bits[5:0] = channel index.
REQ-024 On CMD->DATA, the addressed channel's temperature is snapshotted into the shift register in the same cycle; later updates do not affect the transfer.
REQ-025 Invalid opcode or channel index >= g_num_ch: snapshot is all ones.
REQ-026 DATA: o_spi_so presents snapshot MSB first; the first bit is valid before the next SCK rising edge; each subsequent bit updates on SCK falling edge; after g_temp_width bits -> TAIL.
REQ-027 TAIL: o_spi_so = 0, o_spi_so_en stays high until CS rises.
REQ-028 o_spi_so_en is high in DATA and TAIL only; o_spi_so = 0 whenever o_spi_so_en = 0.
REQ-029 Synchronised CS rising in any state -> IDLE next cycle; partial transfer discarded, no error flagged.
REQ-030 A free-running tick counter counts 0..g_temp_chg_ticks-1 and produces a 1-cycle tick at wrap; an ambient counter advances on each tick and flags every g_amb_div-th tick.
REQ-031 On tick, per channel: heat=1, cool=0 -> +1; cool=1, heat=0 -> -1.
REQ-032 On an ambient tick, per channel with heat = cool (both 0 or both 1): i_amb_hc=1 -> +1, else -1.
REQ-033 Steps saturate at g_temp_min and g_temp_max; no wrap-around.
REQ-034 Channels update independently in the same cycle; temperature updates and SPI snapshots never block each other.

Reset
REQ-035 While i_reset is high at a rising edge: state = IDLE, all temperatures = g_temp_init, tick and ambient counters = 0, shift register and bit counter = 0, synchronisers = idle level (SCK 0, CS 1, SI 0).
REQ-036 Outputs during and after reset: o_spi_so = 0, o_spi_so_en = 0, o_busy = 0, o_temp = g_temp_init in every channel.
REQ-037 Reset asserted mid-transfer aborts the transfer; the block stays IDLE until a fresh CS falling edge.

Verification
REQ-038 Reset, then read command 0x42 with defaults -> SO returns 0x02BC (700), MSB first; o_spi_so_en is high from the first data bit until CS rises.
REQ-039 Channel 1 heat=1 for 3*g_temp_chg_ticks cycles with other channels idle, amb=1 -> ch1 = 703; other channels still 700 (no ambient step yet).
REQ-040 Channel 0 cool=1 and read ch0 started on a tick cycle -> snapshot equals the pre-tick value; o_temp shows the decremented value.
REQ-041 Command 0x47 (channel 7, g_num_ch=4) or opcode 0x80 -> SO returns 0xFFFF; no temperature changes.
REQ-042 Channel at g_temp_max with heat=1 for 10 ticks -> stays 1200; channel at g_temp_min with cool=1 -> stays 0.
REQ-043 CS raised after 4 command bits, then a full read of 0x43 -> first transfer ignored, second returns ch3 correctly; o_busy falls within 3 i_clk cycles of CS rising.
